// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment patterns are active-low, bit 0 = segment a.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } lap_state_t;

endpackage

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed common-anode driver for the stopwatch time,
// with lap freeze, hour leading-zero blanking and a blinking colon.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sh1,
    input  logic [3:0] sh2,
    input  logic [3:0] sm1,
    input  logic [3:0] sm2,
    input  logic [3:0] ss1,
    input  logic [3:0] ss2,
    input  logic       clk_out,
    input  logic       lap,
    input  logic       lz_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frozen
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [23:0]      cap0, cap1, shadow;
    logic             lap_s0, lap_s1, lap_d;
    logic             clko_s0, clko_s1;
    lap_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic             stable, lap_rise, frame_start, cnt_wrap;
    logic             anode_on, dp_on;
    logic [3:0]       cur_digit;
    logic [5:0]       an_next;
    logic [6:0]       dec_seg;

    // Two-stage capture of the asynchronous digit bus; a load is only
    // accepted when both stages agree, so a bus in transition is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap0    <= '0;
            cap1    <= '0;
            lap_s0  <= 1'b0;
            lap_s1  <= 1'b0;
            lap_d   <= 1'b0;
            clko_s0 <= 1'b0;
            clko_s1 <= 1'b0;
        end else begin
            cap0    <= {sh1, sh2, sm1, sm2, ss1, ss2};
            cap1    <= cap0;
            lap_s0  <= lap;
            lap_s1  <= lap_s0;
            lap_d   <= lap_s1;
            clko_s0 <= clk_out;
            clko_s1 <= clko_s0;
        end
    end

    always_comb begin
        stable      = (cap0 == cap1);
        lap_rise    = lap_s1 && !lap_d;
        cnt_wrap    = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_start = cnt_wrap && (idx == 3'(NUM_DIGITS - 1));

        cur_digit = '0;
        case (idx)
            3'd0: cur_digit = shadow[23:20];
            3'd1: cur_digit = shadow[19:16];
            3'd2: cur_digit = shadow[15:12];
            3'd3: cur_digit = shadow[11:8];
            3'd4: cur_digit = shadow[7:4];
            3'd5: cur_digit = shadow[3:0];
            default: cur_digit = '0;
        endcase

        anode_on = (cnt >= CNT_W'(BLANK_CYC))
                && !((idx == 3'd0) && lz_en && (shadow[23:20] == 4'd0));

        an_next = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = !(anode_on && (idx == 3'(i)));
        end

        dp_on = (((idx == 3'd1) || (idx == 3'd3)) && clko_s1)
             || ((idx == 3'd5) && (state == FROZEN));
    end

    seg_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LIVE;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            an     <= '1;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
            frozen <= 1'b0;
        end else begin
            an     <= an_next;
            seg    <= dec_seg;
            dp     <= !(dp_on && anode_on);
            frozen <= (state == FROZEN);

            // A lap edge on a frame start wins: toggle and skip that load.
            if (lap_rise) begin
                state <= (state == LIVE) ? FROZEN : LIVE;
            end else if (frame_start && stable && (state == LIVE)) begin
                shadow <= cap1;
            end

            if (cnt_wrap) begin
                cnt <= '0;
                idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: a cycle reference model feeds a
// scoreboard queue, plus directed checks for each display feature.
module tb_seg_scan_display;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sh1 = 4'd1, sh2 = 4'd2, sm1 = 4'd3, sm2 = 4'd4, ss1 = 4'd5, ss2 = 4'd6;
    logic       clk_out = 1'b0;
    logic       lap = 1'b0;
    logic       lz_en = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frozen;

    int checks = 0;
    int failures = 0;

    seg_scan_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sh1     (sh1),
        .sh2     (sh2),
        .sm1     (sm1),
        .sm2     (sm2),
        .ss1     (ss1),
        .ss2     (ss2),
        .clk_out (clk_out),
        .lap     (lap),
        .lz_en   (lz_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model state
    logic [23:0] m_cap0 = '0, m_cap1 = '0, m_shadow = '0;
    int          m_cnt = 0, m_idx = 0;
    logic        m_frz = 1'b0;
    logic        m_l0 = 1'b0, m_l1 = 1'b0, m_ld = 1'b0, m_c0 = 1'b0, m_c1 = 1'b0;
    logic [14:0] sb[$];

    always @(posedge clk) begin
        logic [5:0] ea;
        logic [3:0] d;
        logic       on, dpon, rise, fs;
        if (rst) begin
            m_cap0 = '0; m_cap1 = '0; m_shadow = '0;
            m_cnt = 0; m_idx = 0; m_frz = 1'b0;
            m_l0 = 1'b0; m_l1 = 1'b0; m_ld = 1'b0; m_c0 = 1'b0; m_c1 = 1'b0;
            sb.push_back({6'h3F, 7'h7F, 1'b1, 1'b0});
        end else begin
            d    = m_shadow[(5 - m_idx) * 4 +: 4];
            on   = (m_cnt >= int'(BLANK_CYC)) && !(m_idx == 0 && lz_en && m_shadow[23:20] == 4'd0);
            ea   = 6'h3F;
            if (on) ea[m_idx] = 1'b0;
            dpon = ((m_idx == 1 || m_idx == 3) && m_c1) || (m_idx == 5 && m_frz);
            sb.push_back({ea, ref_seg(d), !(dpon && on), m_frz});

            rise = m_l1 && !m_ld;
            fs   = (m_cnt == int'(SCAN_DIV) - 1) && (m_idx == 5);
            if (rise) m_frz = !m_frz;
            else if (fs && (m_cap0 == m_cap1) && !m_frz) m_shadow = m_cap1;

            if (m_cnt == int'(SCAN_DIV) - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == 5) ? 0 : m_idx + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_ld = m_l1; m_l1 = m_l0; m_l0 = lap;
            m_c1 = m_c0; m_c0 = clk_out;
            m_cap1 = m_cap0; m_cap0 = {sh1, sh2, sm1, sm2, ss1, ss2};
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("scan", {17'd0, an, seg, dp, frozen}, {17'd0, e});
        end
    end

    task automatic wait_an(input logic [5:0] v);
        int n = 0;
        @(negedge clk);
        while (an !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_an", {26'd0, an}, {26'd0, v});
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        repeat (3) @(negedge clk);
        lap = 1'b0;
    endtask

    initial begin
        int lowcnt;
        // 1. reset and first frames
        repeat (3) @(negedge clk);
        check_eq("rst_an", {26'd0, an}, 32'h3F);
        check_eq("rst_seg", {25'd0, seg}, 32'h7F);
        check_eq("rst_dp", {31'd0, dp}, 32'd1);
        check_eq("rst_frozen", {31'd0, frozen}, 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wait_an(6'h3F & ~(6'd1 << i));
            check_eq("walk_seg", {25'd0, seg}, {25'd0, ref_seg(4'(i + 1))});
        end

        // 2. mid-frame change
        wait_an(6'h3B);
        ss2 = 4'd7;
        wait_an(6'h1F);
        check_eq("midframe_old", {25'd0, seg}, 32'h02);
        wait_an(6'h3E);
        wait_an(6'h1F);
        check_eq("midframe_new", {25'd0, seg}, 32'h78);

        // 3. lap freeze and release
        {sh1, sh2, sm1, sm2, ss1, ss2} = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        repeat (100) @(negedge clk);
        pulse_lap();
        repeat (10) @(negedge clk);
        check_eq("frozen_on", {31'd0, frozen}, 32'd1);
        ss2 = 4'd5;
        repeat (100) @(negedge clk);
        wait_an(6'h1F);
        check_eq("frz_seg5", {25'd0, seg}, 32'h40);
        check_eq("frz_dp5", {31'd0, dp}, 32'd0);
        wait_an(6'h2F);
        check_eq("frz_seg4", {25'd0, seg}, 32'h79);
        pulse_lap();
        repeat (10) @(negedge clk);
        check_eq("frozen_off", {31'd0, frozen}, 32'd0);
        repeat (60) @(negedge clk);
        wait_an(6'h1F);
        check_eq("rel_seg5", {25'd0, seg}, 32'h12);
        check_eq("rel_dp5", {31'd0, dp}, 32'd1);

        // 4. leading-zero blanking
        lz_en = 1'b1;
        repeat (100) @(negedge clk);
        lowcnt = 0;
        repeat (48) begin
            @(negedge clk);
            if (an[0] == 1'b0) lowcnt++;
        end
        check_eq("lz_blank", lowcnt, 0);
        sh1 = 4'd1;
        repeat (100) @(negedge clk);
        lowcnt = 0;
        repeat (48) begin
            @(negedge clk);
            if (an[0] == 1'b0) lowcnt++;
        end
        check_eq("lz_show", lowcnt, 6);

        // 5. invalid digit and colon blink
        lz_en = 1'b0;
        {sh1, sh2, sm1, sm2, ss1, ss2} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC};
        repeat (100) @(negedge clk);
        wait_an(6'h1F);
        check_eq("dash", {25'd0, seg}, 32'h3F);
        clk_out = 1'b1;
        repeat (5) @(negedge clk);
        wait_an(6'h3D);
        check_eq("colon1", {31'd0, dp}, 32'd0);
        wait_an(6'h37);
        check_eq("colon3", {31'd0, dp}, 32'd0);
        wait_an(6'h3B);
        check_eq("colon_idx2", {31'd0, dp}, 32'd1);
        clk_out = 1'b0;
        repeat (5) @(negedge clk);
        wait_an(6'h3D);
        check_eq("colon_off", {31'd0, dp}, 32'd1);

        // 6. reset mid-dwell
        wait_an(6'h37);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_eq("async_rst", {17'd0, an, seg, dp, frozen}, {17'd0, 6'h3F, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        wait_an(6'h3E);
        check_eq("post_rst_shadow", {25'd0, seg}, 32'h40);
        repeat (100) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
